// File: rtl/tbird_tail_fsm_pkg.sv
// Shared definitions for the Thunderbird tail-light sequencer.
// Holds the csl mode codes, which hex_display also uses, and the bus widths.
package tbird_tail_fsm_pkg;

  localparam int unsigned LIGHTS_W = 6;
  localparam int unsigned CSL_W    = 4;

  // csl mode codes as seen by hex_display
  localparam logic [CSL_W-1:0] CSL_IDLE   = 4'h0;
  localparam logic [CSL_W-1:0] CSL_LEFT   = 4'h1;
  localparam logic [CSL_W-1:0] CSL_RIGHT  = 4'h2;
  localparam logic [CSL_W-1:0] CSL_HAZARD = 4'h3;

endpackage

// File: rtl/tbird_tail_fsm_tick_gen.sv
// Free-running step divider for the tail-light sequencer.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous, active-high reset
//   tick out  registered 1-clk pulse, once every TICK_DIV clocks
module tbird_tail_fsm_tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Counter runs 0..TICK_DIV-1; tick pulses for one clock after each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CNT_MAX) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/tbird_tail_fsm.sv
// Thunderbird tail-light sequencer: turns left/right/hazard switch requests into
// a timed 3-lamp-per-side blink pattern and a mode code for hex_display.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   left    in   left-turn request (asynchronous switch)
//   right   in   right-turn request (asynchronous switch)
//   haz     in   hazard request (asynchronous switch)
//   lights  out  {LC,LB,LA,RA,RB,RC}, 1 = lamp on (registered)
//   csl     out  mode code IDLE/LEFT/RIGHT/HAZARD (registered)
// Configuration macro TBIRD_INPUT_SYNC_EN: when defined, the switches go through
// 2-flop synchronizers (2 clocks latency); when undefined they are used raw.
module tbird_tail_fsm
  import tbird_tail_fsm_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                left,
  input  logic                right,
  input  logic                haz,
  output logic [LIGHTS_W-1:0] lights,
  output logic [CSL_W-1:0]    csl
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_LR3
  } state_t;

  state_t              state, state_d;
  logic [LIGHTS_W-1:0] lights_d;
  logic [CSL_W-1:0]    csl_d;
  logic                tick;
  logic                left_s, right_s, haz_s;
  logic                req_h, req_l, req_r;

  tbird_tail_fsm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

`ifdef TBIRD_INPUT_SYNC_EN
  logic [2:0] sync1, sync2;

  // Two-flop synchronizers for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {left, right, haz};
      sync2 <= sync1;
    end
  end

  assign {left_s, right_s, haz_s} = sync2;
`else
  assign {left_s, right_s, haz_s} = {left, right, haz};
`endif

  // Both turn switches together count as a hazard request.
  assign req_h = haz_s | (left_s & right_s);
  assign req_l = left_s & ~req_h;
  assign req_r = right_s & ~req_h;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      lights <= '0;
      csl    <= CSL_IDLE;
    end else begin
      state  <= state_d;
      lights <= lights_d;
      csl    <= csl_d;
    end
  end

  // Next state on tick; lights/csl decoded from the next state so they land with it.
  always_comb begin
    state_d  = state;
    lights_d = '0;
    csl_d    = CSL_IDLE;

    if (tick) begin
      case (state)
        S_IDLE: begin
          if (req_h)      state_d = S_LR3;
          else if (req_l) state_d = S_L1;
          else if (req_r) state_d = S_R1;
        end
        S_L1:    state_d = req_h ? S_LR3 : S_L2;
        S_L2:    state_d = req_h ? S_LR3 : S_L3;
        S_R1:    state_d = req_h ? S_LR3 : S_R2;
        S_R2:    state_d = req_h ? S_LR3 : S_R3;
        S_L3,
        S_R3,
        S_LR3:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_L1:  begin lights_d = 6'b001_000; csl_d = CSL_LEFT;   end
      S_L2:  begin lights_d = 6'b011_000; csl_d = CSL_LEFT;   end
      S_L3:  begin lights_d = 6'b111_000; csl_d = CSL_LEFT;   end
      S_R1:  begin lights_d = 6'b000_100; csl_d = CSL_RIGHT;  end
      S_R2:  begin lights_d = 6'b000_110; csl_d = CSL_RIGHT;  end
      S_R3:  begin lights_d = 6'b000_111; csl_d = CSL_RIGHT;  end
      S_LR3: begin lights_d = 6'b111_111; csl_d = CSL_HAZARD; end
      default: begin
        // IDLE: show the pending request so the display does not flicker between blinks.
        lights_d = '0;
        if (req_h)      csl_d = CSL_HAZARD;
        else if (req_l) csl_d = CSL_LEFT;
        else if (req_r) csl_d = CSL_RIGHT;
        else            csl_d = CSL_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tbird_tail_fsm.sv
// Self-checking bench for tbird_tail_fsm with TICK_DIV=4 and raw (unsynchronized) inputs.
// Table of per-step vectors plus hand-written reset/IDLE sequences; expectations go
// through a scoreboard queue and are compared after the relevant clock edge.
module tb_tbird_tail_fsm;
  import tbird_tail_fsm_pkg::*;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, haz = 1'b0;
  logic [5:0] lights;
  logic [3:0] csl;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [5:0] lt;
    logic [3:0] cs;
  } exp_t;

  typedef struct {
    string      name;
    bit         rst_first;
    bit         l, r, h;
    logic [5:0] lt;
    logic [3:0] cs;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  tbird_tail_fsm #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .left  (left),
    .right (right),
    .haz   (haz),
    .lights(lights),
    .csl   (csl)
  );

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic expect_out(input string name, input logic [5:0] lt, input logic [3:0] cs);
    exp_t e;
    e.name = name;
    e.lt   = lt;
    e.cs   = cs;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got lights=%b csl=%h, required an expectation", lights, csl);
      return;
    end
    e = sb.pop_front();
    if (lights !== e.lt || csl !== e.cs) begin
      n_fail++;
      $display("FAIL %s: got lights=%b csl=%h, required lights=%b csl=%h",
               e.name, lights, csl, e.lt, e.cs);
    end
  endtask

  // Reset for one edge, check, then release and let one more edge pass so
  // each later step spans exactly TICK_DIV edges ending on a state update.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; left = 1'b0; right = 1'b0; haz = 1'b0;
    expect_out("reset", 6'b0, CSL_IDLE);
    @(posedge clk);
    @(negedge clk);
    check_out();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_step(input vec_t v);
    if (v.rst_first) do_reset();
    left = v.l; right = v.r; haz = v.h;
    expect_out(v.name, v.lt, v.cs);
    repeat (TICK_DIV) @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  function automatic void add(input string n, input bit rs, input bit l, input bit r,
                              input bit h, input logic [5:0] lt, input logic [3:0] cs);
    vec_t v;
    v.name = n; v.rst_first = rs; v.l = l; v.r = r; v.h = h; v.lt = lt; v.cs = cs;
    vecs.push_back(v);
  endfunction

  initial begin
    // left held
    add("s1_l1",   1, 1, 0, 0, 6'b001000, CSL_LEFT);
    add("s1_l2",   0, 1, 0, 0, 6'b011000, CSL_LEFT);
    add("s1_l3",   0, 1, 0, 0, 6'b111000, CSL_LEFT);
    add("s1_idle", 0, 1, 0, 0, 6'b000000, CSL_LEFT);
    add("s1_l1b",  0, 1, 0, 0, 6'b001000, CSL_LEFT);
    // right held
    add("s2_r1",   1, 0, 1, 0, 6'b000100, CSL_RIGHT);
    add("s2_r2",   0, 0, 1, 0, 6'b000110, CSL_RIGHT);
    add("s2_r3",   0, 0, 1, 0, 6'b000111, CSL_RIGHT);
    add("s2_idle", 0, 0, 1, 0, 6'b000000, CSL_RIGHT);
    add("s2_r1b",  0, 0, 1, 0, 6'b000100, CSL_RIGHT);
    // hazard interrupts a left sequence at L2
    add("s3_l1",   1, 1, 0, 0, 6'b001000, CSL_LEFT);
    add("s3_l2",   0, 1, 0, 0, 6'b011000, CSL_LEFT);
    add("s3_lr3",  0, 1, 0, 1, 6'b111111, CSL_HAZARD);
    add("s3_idle", 0, 1, 0, 1, 6'b000000, CSL_HAZARD);
    // both turn switches act as hazard
    add("s4_lr3a", 1, 1, 1, 0, 6'b111111, CSL_HAZARD);
    add("s4_idla", 0, 1, 1, 0, 6'b000000, CSL_HAZARD);
    add("s4_lr3b", 0, 1, 1, 0, 6'b111111, CSL_HAZARD);
    add("s4_idlb", 0, 1, 1, 0, 6'b000000, CSL_HAZARD);
    // left released after one step still completes
    add("s5_l1",   1, 1, 0, 0, 6'b001000, CSL_LEFT);
    add("s5_l2",   0, 0, 0, 0, 6'b011000, CSL_LEFT);
    add("s5_l3",   0, 0, 0, 0, 6'b111000, CSL_LEFT);
    add("s5_idle", 0, 0, 0, 0, 6'b000000, CSL_IDLE);
    add("s5_stay", 0, 0, 0, 0, 6'b000000, CSL_IDLE);
    // hazard at L3 does not divert: L3 always returns to IDLE
    add("s7_l1",   1, 1, 0, 0, 6'b001000, CSL_LEFT);
    add("s7_l2",   0, 1, 0, 0, 6'b011000, CSL_LEFT);
    add("s7_l3",   0, 1, 0, 0, 6'b111000, CSL_LEFT);
    add("s7_idle", 0, 0, 0, 1, 6'b000000, CSL_HAZARD);
    add("s7_lr3",  0, 0, 0, 1, 6'b111111, CSL_HAZARD);
    // hazard at R1 diverts to LR3
    add("s8_r1",   1, 0, 1, 0, 6'b000100, CSL_RIGHT);
    add("s8_lr3",  0, 0, 1, 1, 6'b111111, CSL_HAZARD);
    add("s8_idle", 0, 0, 0, 0, 6'b000000, CSL_IDLE);

    foreach (vecs[i]) run_step(vecs[i]);

    // csl tracks requests within one clock while IDLE, lights stay dark
    do_reset();
    right = 1'b1;
    expect_out("idle_csl_right", 6'b0, CSL_RIGHT);
    @(posedge clk);
    @(negedge clk);
    check_out();
    right = 1'b0;
    expect_out("idle_csl_clear", 6'b0, CSL_IDLE);
    @(posedge clk);
    @(negedge clk);
    check_out();

    // reset in L3 clears at once; the first step comes TICK_DIV clocks after the
    // first post-release edge
    begin
      vec_t v;
      v.rst_first = 1'b1; v.l = 1'b1; v.r = 1'b0; v.h = 1'b0; v.cs = CSL_LEFT;
      v.name = "s6_l1"; v.lt = 6'b001000; run_step(v);
      v.rst_first = 1'b0;
      v.name = "s6_l2"; v.lt = 6'b011000; run_step(v);
      v.name = "s6_l3"; v.lt = 6'b111000; run_step(v);
    end
    rst = 1'b1;
    expect_out("s6_rst_in_l3", 6'b0, CSL_IDLE);
    @(posedge clk);
    @(negedge clk);
    check_out();
    rst = 1'b0;
    for (int k = 1; k <= int'(TICK_DIV); k++) begin
      expect_out($sformatf("s6_wait%0d", k), 6'b0, CSL_LEFT);
      @(posedge clk);
      @(negedge clk);
      check_out();
    end
    expect_out("s6_first_step", 6'b001000, CSL_LEFT);
    @(posedge clk);
    @(negedge clk);
    check_out();

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
